// File: rtl/pipe_mult.sv
// Pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed per operation.
// Latency: ceil(WIDTH/ROWS_PER_STAGE)+1 enabled cycles (input register, CSA stages, final adder).
// Backpressure: none; ce=0 freezes every register, rst clears valids/outputs regardless of ce.
module pipe_mult #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic                 out_tc,
    output logic [2*WIDTH-1:0]   p
);

    localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;

    // Slot 0 is the input register; slot k+1 holds the result of CSA stage k.
    // Operands are only needed by the CSA stages, so they stop at slot STAGES-1.
    logic [WIDTH-1:0]   a_q  [0:STAGES-1];
    logic [WIDTH-1:0]   a_d  [0:STAGES-1];
    logic [WIDTH-1:0]   b_q  [0:STAGES-1];
    logic [WIDTH-1:0]   b_d  [0:STAGES-1];
    logic               tc_q [0:STAGES];
    logic               tc_d [0:STAGES];
    logic               vld_q[0:STAGES];
    logic               vld_d[0:STAGES];
    // Carry-save pair aligned to the next unretired product bit, plus retired low bits.
    logic [WIDTH-1:0]   s_q  [0:STAGES];
    logic [WIDTH-1:0]   s_d  [0:STAGES];
    logic [WIDTH-1:0]   c_q  [0:STAGES];
    logic [WIDTH-1:0]   c_d  [0:STAGES];
    logic [WIDTH-1:0]   lo_q [0:STAGES];
    logic [WIDTH-1:0]   lo_d [0:STAGES];

    logic [2*WIDTH-1:0] p_q, p_d;
    logic               out_valid_q, out_valid_d;
    logic               out_tc_q, out_tc_d;

    // Row-reduction scratch.
    logic [WIDTH-1:0]   acc_s, acc_c, acc_lo, pp, fa_s, fa_c, hi_sum;

    // Next-state for the whole pipeline: capture, CSA row reduction, final carry resolve.
    always_comb begin
        for (int k = 0; k <= STAGES; k++) begin
            tc_d[k]  = 1'b0;
            vld_d[k] = 1'b0;
            s_d[k]   = '0;
            c_d[k]   = '0;
            lo_d[k]  = '0;
        end
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
        end
        acc_s  = '0;
        acc_c  = '0;
        acc_lo = '0;
        pp     = '0;
        fa_s   = '0;
        fa_c   = '0;

        a_d[0]   = a;
        b_d[0]   = b;
        tc_d[0]  = in_tc;
        vld_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
        end

        // Row i is handled by stage i/ROWS_PER_STAGE; each row retires product bit i.
        for (int i = 0; i < WIDTH; i++) begin
            if (i % ROWS_PER_STAGE == 0) begin
                acc_s  = s_q[i/ROWS_PER_STAGE];
                acc_c  = c_q[i/ROWS_PER_STAGE];
                acc_lo = lo_q[i/ROWS_PER_STAGE];
            end
            pp = a_q[i/ROWS_PER_STAGE] & {WIDTH{b_q[i/ROWS_PER_STAGE][i]}};
            if (tc_q[i/ROWS_PER_STAGE]) begin
                // Baugh-Wooley: last row inverted except its MSB, other rows MSB inverted.
                if (i == WIDTH-1) begin
                    pp = ~pp;
                end
                pp[WIDTH-1] = ~pp[WIDTH-1];
            end
            fa_s      = acc_s ^ acc_c ^ pp;
            fa_c      = (acc_s & acc_c) | (acc_s & pp) | (acc_c & pp);
            acc_lo[i] = fa_s[0];
            acc_s     = {1'b0, fa_s[WIDTH-1:1]};
            acc_c     = fa_c;
            // The vacated sum MSB carries the correction constants: after row 0 it has
            // weight 2^WIDTH, after the last row weight 2^(2*WIDTH-1).
            if (tc_q[i/ROWS_PER_STAGE] && (i == 0 || i == WIDTH-1)) begin
                acc_s[WIDTH-1] = 1'b1;
            end
            if ((i % ROWS_PER_STAGE == ROWS_PER_STAGE-1) || (i == WIDTH-1)) begin
                s_d[i/ROWS_PER_STAGE+1]   = acc_s;
                c_d[i/ROWS_PER_STAGE+1]   = acc_c;
                lo_d[i/ROWS_PER_STAGE+1]  = acc_lo;
                tc_d[i/ROWS_PER_STAGE+1]  = tc_q[i/ROWS_PER_STAGE];
                vld_d[i/ROWS_PER_STAGE+1] = vld_q[i/ROWS_PER_STAGE];
            end
        end

        // Carries beyond bit 2*WIDTH-1 are dropped, giving the modular signed result.
        hi_sum      = s_q[STAGES] + c_q[STAGES];
        p_d         = {hi_sum, lo_q[STAGES]};
        out_valid_d = vld_q[STAGES];
        out_tc_d    = tc_q[STAGES];
    end

    // Pipeline registers: reset wins over ce, ce=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                tc_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
                s_q[k]   <= '0;
                c_q[k]   <= '0;
                lo_q[k]  <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            p_q         <= '0;
            out_valid_q <= 1'b0;
            out_tc_q    <= 1'b0;
        end else if (ce) begin
            for (int k = 0; k <= STAGES; k++) begin
                tc_q[k]  <= tc_d[k];
                vld_q[k] <= vld_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                lo_q[k]  <= lo_d[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            out_tc_q    <= out_tc_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;
    assign out_tc    = out_tc_q;

endmodule

// File: tb/tb_pipe_mult.sv
// Bench for pipe_mult: an 8x8 single-row-per-stage instance and a 16x16 four-rows-per-stage
// instance share clock, reset and clock enable; expected products are queued with the
// enabled-edge number on which they must appear.
module tb_pipe_mult;

    localparam int LAT8  = 9;
    localparam int LAT16 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce;
    logic        v8, tc8, ov8, otc8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        v16, tc16, ov16, otc16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    pipe_mult #(.WIDTH(8), .ROWS_PER_STAGE(1)) u_m8 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v8), .in_tc(tc8), .a(a8), .b(b8),
        .out_valid(ov8), .out_tc(otc8), .p(p8)
    );

    pipe_mult #(.WIDTH(16), .ROWS_PER_STAGE(4)) u_m16 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v16), .in_tc(tc16), .a(a16), .b(b16),
        .out_valid(ov16), .out_tc(otc16), .p(p16)
    );

    typedef struct {
        logic [31:0] p;
        logic        tc;
        int          due;
    } item_t;

    item_t       q0[$];
    item_t       q1[$];
    int          en_cnt = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic        mv [2];
    logic        mtc[2];
    logic [31:0] mp [2];
    bit          rs, cs;

    function automatic logic [31:0] ref_mul(input int w, input bit tc,
                                            input logic [15:0] x, input logic [15:0] y);
        longint sx, sy, pr, m;
        sx = longint'(x);
        sy = longint'(y);
        if (tc && x[w-1]) sx = sx - (longint'(1) << w);
        if (tc && y[w-1]) sy = sy - (longint'(1) << w);
        pr = sx * sy;
        m  = (longint'(1) << (2*w)) - 1;
        pr = pr & m;
        return pr[31:0];
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[inst%0d] @edge %0d: observed %0h expected %0h",
                   tag, idx, en_cnt, obs, exp);
        end
    endtask

    task automatic mon(input int idx, input bit r, input bit c, input logic ov,
                       input logic otc, input logic [31:0] pv);
        item_t it;
        bit    ev;
        if (r) begin
            chk("rst_valid", idx, {31'b0, ov}, 32'd0);
            chk("rst_p", idx, pv, 32'd0);
            chk("rst_tc", idx, {31'b0, otc}, 32'd0);
            mv[idx]  = 1'b0;
            mp[idx]  = '0;
            mtc[idx] = 1'b0;
        end else if (!c) begin
            chk("hold_valid", idx, {31'b0, ov}, {31'b0, mv[idx]});
            if (mv[idx]) begin
                chk("hold_p", idx, pv, mp[idx]);
                chk("hold_tc", idx, {31'b0, otc}, {31'b0, mtc[idx]});
            end
        end else begin
            ev = 1'b0;
            it = '{p: '0, tc: 1'b0, due: 0};
            if (idx == 0) begin
                if (q0.size() > 0 && q0[0].due == en_cnt) begin
                    ev = 1'b1;
                    it = q0.pop_front();
                end
            end else begin
                if (q1.size() > 0 && q1[0].due == en_cnt) begin
                    ev = 1'b1;
                    it = q1.pop_front();
                end
            end
            chk("out_valid", idx, {31'b0, ov}, {31'b0, ev});
            mv[idx] = ev;
            if (ev) begin
                mp[idx]  = it.p;
                mtc[idx] = it.tc;
                chk("p", idx, pv, it.p);
                chk("out_tc", idx, {31'b0, otc}, {31'b0, it.tc});
            end
        end
    endtask

    // Observe both instances 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            rs = rst;
            cs = ce;
            if (cs && !rs) en_cnt++;
            #1;
            mon(0, rs, cs, ov8, otc8, {16'h0, p8});
            mon(1, rs, cs, ov16, otc16, p16);
        end
    end

    task automatic issue_now(input bit v8i, input bit tc8i, input logic [7:0] a8i,
                             input logic [7:0] b8i, input bit v16i, input bit tc16i,
                             input logic [15:0] a16i, input logic [15:0] b16i);
        item_t it;
        v8 = v8i; tc8 = tc8i; a8 = a8i; b8 = b8i;
        v16 = v16i; tc16 = tc16i; a16 = a16i; b16 = b16i;
        if (ce && !rst) begin
            if (v8i) begin
                it = '{p: ref_mul(8, tc8i, {8'h0, a8i}, {8'h0, b8i}), tc: tc8i,
                       due: en_cnt + 1 + LAT8};
                q0.push_back(it);
            end
            if (v16i) begin
                it = '{p: ref_mul(16, tc16i, a16i, b16i), tc: tc16i,
                       due: en_cnt + 1 + LAT16};
                q1.push_back(it);
            end
        end
    endtask

    task automatic issue(input bit v8i, input bit tc8i, input logic [7:0] a8i,
                         input logic [7:0] b8i, input bit v16i, input bit tc16i,
                         input logic [15:0] a16i, input logic [15:0] b16i);
        @(negedge clk);
        issue_now(v8i, tc8i, a8i, b8i, v16i, tc16i, a16i, b16i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 8'h0, 8'h0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic stall_run(input int pre);
        issue(1, 0, 8'd200, 8'd3, 1, 1, 16'h1234, 16'hFEDC);
        issue(1, 1, 8'hF0, 8'h11, 1, 0, 16'hABCD, 16'h0101);
        issue(1, 0, 8'd7, 8'd9, 1, 1, 16'h8000, 16'h8000);
        idle(pre);
        @(negedge clk);
        ce = 1'b0; v8 = 1'b0; v16 = 1'b0;
        repeat (4) @(negedge clk);
        ce = 1'b1;
        idle(15);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        v8 = 0; tc8 = 0; a8 = '0; b8 = '0;
        v16 = 0; tc16 = 0; a16 = '0; b16 = '0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mtc[i] = 1'b0; mp[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single unsigned max*max, then silence on both sides.
        issue(1, 0, 8'hFF, 8'hFF, 1, 0, 16'hFFFF, 16'hFFFF);
        idle(12);

        // Signed corner cases back to back.
        issue(1, 1, 8'h80, 8'h80, 1, 1, 16'h8000, 16'hFFFF);
        issue(1, 1, 8'hFF, 8'h7F, 1, 1, 16'h8000, 16'h8000);
        issue(1, 1, 8'h80, 8'h7F, 1, 1, 16'h7FFF, 16'h8000);
        issue(1, 0, 8'h80, 8'h80, 1, 0, 16'h0000, 16'hFFFF);
        idle(12);

        // Random stream, mode alternating every cycle, random bubbles.
        for (int i = 0; i < 256; i++) begin
            issue($urandom_range(0, 3) != 0, i[0], 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, ~i[0], 16'($urandom), 16'($urandom));
        end
        idle(12);

        // Stall mid-pipeline, then stall while a result sits on the output.
        stall_run(3);
        stall_run(7);

        // Reset with five operations in flight, new operation right after.
        for (int i = 0; i < 5; i++) begin
            issue(1, i[0], 8'(8'd30 + i), 8'd77, 1, i[1], 16'(16'd999 * i), 16'hC001);
        end
        @(negedge clk);
        rst = 1'b1; v8 = 1'b0; v16 = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        rst = 1'b0;
        issue_now(1, 1, 8'h9C, 8'h64, 1, 0, 16'hFFFF, 16'h0002);
        idle(12);

        // Reset coinciding with ce low: reset must still take effect.
        issue(1, 0, 8'd12, 8'd13, 1, 0, 16'd500, 16'd600);
        issue(1, 1, 8'hFE, 8'hFE, 1, 1, 16'hFFFE, 16'h0003);
        @(negedge clk);
        rst = 1'b1; ce = 1'b0; v8 = 1'b0; v16 = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        rst = 1'b0; ce = 1'b1;
        idle(12);

        chk("q0_drained", 0, q0.size(), 32'd0);
        chk("q1_drained", 1, q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_mult.md
# pipe_mult

Parametrised pipelined array multiplier: the successor to the fixed 8x8 unsigned carry-save pipeline. It multiplies two WIDTH-bit operands, unsigned or two's-complement as selected per operation, and produces a 2·WIDTH-bit product. The array reduces ROWS_PER_STAGE partial-product rows per pipeline stage. A valid flag travels with each operation, and a clock enable lets the surrounding datapath stall it. It sits in the datapath wherever a fully pipelined multiply with one result per cycle is needed.

## Interface
- WIDTH, default 8: operand width; legal range 2..32.
- ROWS_PER_STAGE, default 1: partial-product rows reduced per stage; legal range 1..WIDTH.
- STAGES (derived, not overridable): ceil(WIDTH/ROWS_PER_STAGE).
- LATENCY (derived, not overridable): STAGES+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; low freezes every pipeline register.
- in_valid  in  1  a, b, in_tc carry an operation this cycle.
- in_tc  in  1  1 = two's-complement operands, 0 = unsigned.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  p holds a completed product.
- out_tc  out  1  in_tc of the operation currently on p.
- p  out  2·WIDTH  product, registered.

## Operation
- Partial-product row i is a & {WIDTH{b[i]}}.
- Rows are reduced carry-save, ROWS_PER_STAGE rows per stage. Sum and carry vectors are registered between stages.
- Each stage retires its low product bits; those bits are delayed to align at the output.
- The final stage resolves the remaining carries into the top WIDTH bits of p.
- Unsigned mode: p = a·b, range 0..(2^WIDTH−1)^2.
- Signed mode: Baugh-Wooley. Invert the MSB terms of each row and the whole last row, then add correction constants 2^WIDTH and 2^(2·WIDTH−1) modulo 2^(2·WIDTH). p is the exact two's-complement product, including (−2^(WIDTH−1))^2.
- in_tc is pipelined alongside the data, so modes may change every cycle with no bubble.
- in_valid=0 still advances data registers; only the valid flag marks the bubble. p is don't-care while out_valid=0.
- ce=0 holds all registers (data, tc and valid) unchanged, including out_valid and p; no operation is lost or duplicated.
- rst=1 applies regardless of ce:
  - clears every valid bit, out_valid, out_tc and p to 0;
  - in-flight operations are discarded;
  - data registers may also clear.
- The cycle rst deasserts, a new in_valid is accepted normally.

## Timing
- Reset values: out_valid=0, out_tc=0, p=0.
- Operation sampled at edge k with ce=1 appears on p/out_valid at edge k+LATENCY, counting only edges with ce=1.
  - WIDTH=8, RPS=1: LATENCY=9.
  - WIDTH=8, RPS=2: LATENCY=5.
  - WIDTH=16, RPS=4: LATENCY=5.
- Throughput: one operation per enabled cycle; no back-pressure beyond ce.
- out_valid pulses high for one enabled cycle per input operation. Consecutive inputs give consecutive outputs in order.
- rst and ce=0 in the same cycle: reset wins.
- rst asserted at edge r: out_valid=0 from edge r until the first operation accepted after r has traversed LATENCY enabled edges.
- Critical path: at most ROWS_PER_STAGE carry-save adder rows. The final stage holds a WIDTH-bit ripple or equivalent adder.

## Test plan
- WIDTH=8, RPS=1, unsigned: a=255, b=255, single valid pulse -> out_valid exactly 9 cycles later, p=0xFE01, out_tc=0; out_valid low before and after.
- WIDTH=8 signed: a=0x80, b=0x80 -> p=0x4000. Then a=0xFF, b=0x7F -> p=0xFF81 (−127). Then a=0x80, b=0x7F -> p=0xC080 (−16256).
- Back-to-back stream over 256 cycles, random a/b, in_tc alternating each cycle, random in_valid gaps -> every output matches the reference model in order; out_tc tracks; gaps preserved.
- ce stall: issue 3 operations, drop ce for 4 cycles mid-pipeline -> p, out_valid, out_tc frozen during stall. The 3 results appear in order, delayed by exactly 4 cycles.
- Reset mid-flight: 5 operations in flight, rst high 1 cycle -> out_valid=0 and p=0 next edge; none of the 5 ever appear. A new operation issued on the first post-reset cycle emerges after LATENCY.
- WIDTH=16, RPS=4: a=0xFFFF, b=0xFFFF unsigned -> p=0xFFFE0001 after 5 cycles. Signed a=0x8000, b=0xFFFF -> p=0x00008000.
